// File: rtl/obsidian_pkg.sv
// Shared definitions for the obsidian datapath: ALU codes, R-type funct values,
// instruction field layout and the issue-sequencer state encoding.
package obsidian_pkg;

  localparam int XLEN = 32;
  localparam int RLEN = 5;

  localparam logic [2:0] ALU_OR  = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SRA   = 6'h03;

  // Field order fixes the bit positions: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
  typedef struct packed {
    logic [5:0]      op;
    logic [RLEN-1:0] rs;
    logic [RLEN-1:0] rt;
    logic [RLEN-1:0] rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
  } rtype_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/obsidian_alu_decode.sv
// Combinational R-type decoder: op/funct to ALU control code plus legality.
module obsidian_alu_decode
  import obsidian_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_OR;
    legal       = (op == OP_RTYPE);
    case (funct)
      FN_OR:   alu_control = ALU_OR;
      FN_ADD:  alu_control = ALU_ADD;
      FN_AND:  alu_control = ALU_AND;
      FN_XOR:  alu_control = ALU_XOR;
      FN_SUB:  alu_control = ALU_SUB;
      FN_SRA:  alu_control = ALU_SRA;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/obsidian_alu_seq.sv
// Five-state issue sequencer: accept, decode, read operands, capture ALU result,
// write back. Illegal words bounce straight back to IDLE with a one-cycle pulse.
module obsidian_alu_seq
  import obsidian_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [RLEN-1:0] rf_ra_addr,
  output logic [RLEN-1:0] rf_rb_addr,
  input  logic [XLEN-1:0] rf_ra_data,
  input  logic [XLEN-1:0] rf_rb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  output logic [4:0]      alu_shamt,
  input  logic [XLEN-1:0] alu_c,
  output logic            wb_en,
  output logic [RLEN-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            busy
);

  state_e state, nxt;
  rtype_t iq;
  logic [2:0] dec_ctl;
  logic       dec_legal;

  obsidian_alu_decode u_dec (
    .op          (iq.op),
    .funct       (iq.funct),
    .alu_control (dec_ctl),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (instr_valid && instr_ready) nxt = S_DECODE;
      S_DECODE: nxt = dec_legal ? S_READ : S_IDLE;
      S_READ:   nxt = S_EXEC;
      S_EXEC:   nxt = S_WB;
      S_WB:     nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq          <= '0;
      instr_ready <= 1'b0;
      illegal     <= 1'b0;
      wb_en       <= 1'b0;
      rf_ra_addr  <= '0;
      rf_rb_addr  <= '0;
      alu_control <= '0;
      alu_shamt   <= '0;
      wb_addr     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_data     <= '0;
    end else begin
      // Ready is registered from the next state so it is high exactly while in IDLE.
      instr_ready <= (nxt == S_IDLE);
      illegal     <= (state == S_DECODE) && !dec_legal;
      wb_en       <= (state == S_EXEC) && (wb_addr != '0);
      case (state)
        S_IDLE:   if (instr_valid && instr_ready) iq <= rtype_t'(instr);
        S_DECODE: if (dec_legal) begin
          rf_ra_addr  <= iq.rs;
          rf_rb_addr  <= iq.rt;
          alu_control <= dec_ctl;
          alu_shamt   <= iq.shamt;
          wb_addr     <= iq.rd;
        end
        S_READ: begin
          alu_a <= rf_ra_data;
          alu_b <= rf_rb_data;
        end
        S_EXEC:   wb_data <= alu_c;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_obsidian_alu_seq.sv
// Directed plus random bench for obsidian_alu_seq with an instruction-level model
// of the register file contents and R-type arithmetic.
module tb_obsidian_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_ra_data, rf_rb_data;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wb_seen = 0;
  int wb_exp = 0;
  int last_acc = 0;

  logic [31:0] regs [32];

  obsidian_alu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_shamt   (alu_shamt),
    .alu_c       (alu_c),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // The sequencer registers the read address, so the array read itself is combinational.
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  always_comb begin
    alu_c = '0;
    case (alu_control)
      3'b000: alu_c = alu_a | alu_b;
      3'b001: alu_c = alu_a + alu_b;
      3'b010: alu_c = alu_a & alu_b;
      3'b011: alu_c = alu_a ^ alu_b;
      3'b100: alu_c = alu_a - alu_b;
      3'b101: alu_c = $signed(alu_b) >>> alu_shamt;
      default: alu_c = '0;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wb_en === 1'b1) wb_seen <= wb_seen + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit m_legal(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn inside {6'h25, 6'h20, 6'h24, 6'h26, 6'h22, 6'h03});
  endfunction

  function automatic logic [2:0] m_ctl(input logic [5:0] fn);
    case (fn)
      6'h25: return 3'd0;
      6'h20: return 3'd1;
      6'h24: return 3'd2;
      6'h26: return 3'd3;
      6'h22: return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] m_res(input logic [5:0] fn, input logic [31:0] a, b,
                                        input logic [4:0] sh);
    case (fn)
      6'h25: return a | b;
      6'h20: return a + b;
      6'h24: return a & b;
      6'h26: return a ^ b;
      6'h22: return a - b;
      default: return $signed(b) >>> sh;
    endcase
  endfunction

  // Issue one word and check every stage; with hold set, valid stays up carrying next_w.
  task automatic issue(input logic [31:0] w, input bit hold, input logic [31:0] next_w,
                       input int gap);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    int t;
    {op, rs, rt, rd, sh, fn} = w;
    instr = w;
    instr_valid = 1'b1;
    t = 0;
    while (instr_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (instr_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (gap > 0) chk("accept_gap", cyc - last_acc, gap);
    last_acc = cyc;
    if (hold) instr = next_w;
    else instr_valid = 1'b0;
    chk("busy_c1", busy, 1);
    chk("ready_c1", instr_ready, 0);
    @(negedge clk);
    if (!m_legal(op, fn)) begin
      chk("illegal_c2", illegal, 1);
      chk("ready_c2_ill", instr_ready, 1);
      chk("busy_c2_ill", busy, 0);
      chk("wb_en_ill", wb_en, 0);
      @(negedge clk);
      chk("illegal_c3", illegal, 0);
      return;
    end
    chk("illegal_legal", illegal, 0);
    chk("ra_addr", rf_ra_addr, rs);
    chk("rb_addr", rf_rb_addr, rt);
    chk("alu_control", alu_control, m_ctl(fn));
    chk("alu_shamt", alu_shamt, sh);
    @(negedge clk);
    chk("alu_a", alu_a, regs[rs]);
    chk("alu_b", alu_b, regs[rt]);
    @(negedge clk);
    chk("wb_en_c4", wb_en, (rd != 0));
    chk("wb_addr", wb_addr, rd);
    chk("wb_data", wb_data, m_res(fn, regs[rs], regs[rt], sh));
    if (rd != 0) wb_exp++;
    @(negedge clk);
    chk("wb_en_c5", wb_en, 0);
    chk("ready_c5", instr_ready, 1);
    chk("busy_c5", busy, 0);
  endtask

  initial begin
    logic [5:0] fn, op;
    logic [5:0] lf [6];
    lf[0] = 6'h25; lf[1] = 6'h20; lf[2] = 6'h24;
    lf[3] = 6'h26; lf[4] = 6'h22; lf[5] = 6'h03;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[4] = 32'h8000_0010;
    regs[5] = 32'd1;
    regs[6] = 32'hFFFF_0000;
    regs[7] = 32'h0F0F_0F0F;

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_ctl", alu_control, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);

    issue(mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 0, 0);   // ADD 5+7
    issue(mk(6'h00, 5'd0, 5'd4, 5'd9, 5'd4, 6'h03), 0, 0, 0);   // SRA
    issue(mk(6'h00, 5'd0, 5'd5, 5'd10, 5'd0, 6'h22), 0, 0, 0);  // SUB wrap
    issue(mk(6'h00, 5'd6, 5'd7, 5'd11, 5'd0, 6'h26), 0, 0, 0);  // XOR
    issue(mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 0, 0, 0);   // illegal funct
    issue(mk(6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 0, 0);   // illegal op
    issue(mk(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 0, 0, 0);   // rd = r0
    issue(mk(6'h00, 5'd6, 5'd7, 5'd12, 5'd0, 6'h25), 1,
          mk(6'h00, 5'd6, 5'd7, 5'd13, 5'd0, 6'h24), 0);
    issue(mk(6'h00, 5'd6, 5'd7, 5'd13, 5'd0, 6'h24), 0, 0, 5);  // back-to-back AND

    // Reset while in EXEC: everything clears and the write-back never happens.
    instr = mk(6'h00, 5'd1, 5'd2, 5'd14, 5'd0, 6'h20);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_wb_en", wb_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", instr_ready, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_wb_addr", wb_addr, 0);
    chk("mid_rst_ra", rf_ra_addr, 0);
    chk("mid_rst_ctl", alu_control, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", instr_ready, 1);
    chk("wb_count_after_rst", wb_seen, wb_exp);
    issue(mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : lf[$urandom_range(0, 5)];
      issue(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn), 0, 0, 0);
    end

    chk("wb_pulse_count", wb_seen, wb_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
